// File: rtl/interrupt_controller_pkg.sv
// Shared microcode package: interrupt count, cpu_status enable bit position
// and the index<->vector helpers used by interrupt_controller.
package pa_microcode;

  localparam int IRQ_COUNT         = 8;
  localparam int IRQ_IDX_W         = 3;
  localparam int CPU_STATUS_IE_BIT = 5;

  typedef struct packed {
    logic                 valid;
    logic [IRQ_IDX_W-1:0] idx;
  } irq_winner_t;

  function automatic logic [7:0] irq_idx_to_vector(input logic [7:0] base,
                                                   input logic [IRQ_IDX_W-1:0] idx);
    return base + {4'b0, idx, 1'b0};
  endfunction

  function automatic logic [IRQ_IDX_W-1:0] irq_vector_to_idx(input logic [7:0] base,
                                                             input logic [7:0] vec);
    logic [7:0] off;
    off = vec - base;
    return off[3:1];
  endfunction

  // Lowest set bit wins; scanning downward lets the lowest index overwrite last.
  function automatic irq_winner_t irq_lowest(input logic [IRQ_COUNT-1:0] act);
    irq_winner_t w;
    w = '0;
    for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
      if (act[i]) begin
        w.valid = 1'b1;
        w.idx   = IRQ_IDX_W'(i);
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One request line: optional two-flop synchronizer (IRQ_SYNC_EN), then a
// previous-level register and a rising-edge pulse.
module irq_sync_edge (
  input  logic clk,
  input  logic arst,
  input  logic irq,
  output logic rise
);

`ifdef IRQ_SYNC_EN
  logic meta;
`endif
  logic s;
  logic prev;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
`ifdef IRQ_SYNC_EN
      meta <= 1'b0;
`endif
      s    <= 1'b0;
      prev <= 1'b0;
    end else begin
`ifdef IRQ_SYNC_EN
      meta <= irq;
      s    <= meta;
`else
      s    <= irq;
`endif
      prev <= s;
    end
  end

  // prev resets low, so a line already high at reset release yields one edge.
  assign rise = s & ~prev;

endmodule

// File: rtl/interrupt_controller.sv
// Eight-line edge-latched interrupt controller with mask, fixed priority
// (irq 0 highest) and a registered vector. Build option: IRQ_SYNC_EN.
module interrupt_controller
  import pa_microcode::*;
#(
  parameter int         IRQ_COUNT   = 8,
  parameter logic [7:0] VECTOR_BASE = 8'h00
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [IRQ_COUNT-1:0] irq_in,
  input  logic [7:0]           z_bus,
  input  logic                 irq_masks_wrt,
  input  logic                 int_vector_wrt,
  input  logic                 int_ack,
  input  logic                 clear_all_ints,
  input  logic                 irq_en,
  output logic                 int_pending,
  output logic [7:0]           int_vector,
  output logic [IRQ_COUNT-1:0] irq_masks,
  output logic [IRQ_COUNT-1:0] irq_status
);

  logic [IRQ_COUNT-1:0] rise;
  logic [IRQ_COUNT-1:0] pend;
  logic [IRQ_COUNT-1:0] act;
  logic [IRQ_COUNT-1:0] clr;
  logic [IRQ_IDX_W-1:0] ack_idx;
  irq_winner_t          win;

  for (genvar g = 0; g < IRQ_COUNT; g++) begin : g_line
    irq_sync_edge u_sync (
      .clk  (clk),
      .arst (arst),
      .irq  (irq_in[g]),
      .rise (rise[g])
    );
  end

  assign act     = pend & irq_masks;
  assign win     = irq_lowest(act);
  assign ack_idx = irq_vector_to_idx(VECTOR_BASE, int_vector);

  // Sequencer protocol: int_pending requests service; the trap routine latches
  // int_vector (int_vector_wrt low), reads it, then returns int_ack for that
  // vector or clear_all_ints. An ack for an already-clear bit is harmless.
  always_comb begin
    clr = '0;
    if (clear_all_ints) clr = '1;
    else if (int_ack)   clr[ack_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pend       <= '0;
      irq_masks  <= '0;
      int_vector <= '0;
    end else begin
      // A fresh edge survives a simultaneous clear.
      pend <= (pend & ~clr) | rise;
      if (!irq_masks_wrt) irq_masks <= z_bus;
      if (!int_vector_wrt && win.valid)
        int_vector <= irq_idx_to_vector(VECTOR_BASE, win.idx);
    end
  end

  assign int_pending = irq_en & (|act);
  assign irq_status  = pend;

endmodule
